// File: rtl/flag_mon_pkg.sv
// Purpose : shared types and result encodings for the flag window scheduler.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: scheduler state enum, result_code encodings and a helper that
// turns the two "seen" bits collected over a window into a result code.
package flag_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_OPEN   = 3'd2,
    ST_CLOSE  = 3'd3,
    ST_GAP    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // result_code values; RES_NONE is what the code port shows outside CLOSE
  // and is never strobed with result_valid.
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_ST0  = 2'b01;
  localparam logic [1:0] RES_ST1  = 2'b10;
  localparam logic [1:0] RES_INV  = 2'b11;

  // Both levels observed -> invalid; otherwise whichever level was seen.
  // A window always has at least one sample, so (0,0) cannot occur in CLOSE.
  function automatic logic [1:0] classify(input logic seen0, input logic seen1);
    logic [1:0] code;
    if (seen0 && seen1) code = RES_INV;
    else if (seen1)     code = RES_ST1;
    else if (seen0)     code = RES_ST0;
    else                code = RES_NONE;
    return code;
  endfunction

endpackage

// File: rtl/flag_ch_classifier.sv
// Purpose : find the lowest set bit of an enable mask at or above a start index.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   en_mask   - channels eligible for selection
//   start_idx - first index to consider (one bit wider than CH_W so that
//               "one past the last channel" is representable and finds nothing)
//   next_idx  - lowest enabled index >= start_idx (0 when found is low)
//   found     - a qualifying channel exists
module flag_ch_classifier #(
  parameter int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] en_mask,
  input  logic [CH_W:0]   start_idx,
  output logic [CH_W-1:0] next_idx,
  output logic            found
);

  // Scan from the top down so the lowest qualifying index is written last.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_mask[i] && (i >= int'(start_idx))) begin
        found    = 1'b1;
        next_idx = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/flag_window_scheduler.sv
// Purpose : sweep observation windows over N_CH flags, classify each as stable-0/1 or invalid.
// Latency : start at edge 0 -> SELECT cycle 1, window cycles 2..W+1, result cycle W+2 (one channel).
// Backpressure: none; start is ignored while busy, results are one-cycle strobes with no ready.
//
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   start                   - begin a sweep (accepted only in IDLE)
//   continuous              - sampled at each sweep end: restart instead of finishing
//   win_len, gap_len        - window length (0 acts as 1), post-window gap (0 = none)
//   ch_enable               - channels included in the sweep
//   flag_in                 - raw flags
//   busy, window, sel_ch    - sequencing status
//   result_valid/_ch/_code  - classification strobe
//   flag_out                - last stable value per channel
//   done                    - end of a non-continuous run
module flag_window_scheduler
  import flag_mon_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [CNT_W-1:0] win_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [N_CH-1:0]  ch_enable,
  input  logic [N_CH-1:0]  flag_in,
  output logic             busy,
  output logic             window,
  output logic [CH_W-1:0]  sel_ch,
  output logic             result_valid,
  output logic [CH_W-1:0]  result_ch,
  output logic [1:0]       result_code,
  output logic [N_CH-1:0]  flag_out,
  output logic             done
);

  state_t state, state_d;

  logic [CH_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic             seen0, seen1;
  logic [CNT_W-1:0] cap_win;
  logic [CNT_W-1:0] cap_gap;
  logic [N_CH-1:0]  cap_en;
  logic [N_CH-1:0]  flag_q;

  // Lookup of the first enabled channel. In IDLE the config has not been
  // captured yet, so the decision at the start edge uses the live mask.
  logic [N_CH-1:0] first_mask;
  logic [CH_W-1:0] first_idx;
  logic            first_found;

  // Lookup of the next enabled channel above the current one.
  logic [CH_W:0]   next_start;
  logic [CH_W-1:0] next_idx;
  logic            next_found;

  assign first_mask = (state == ST_IDLE) ? ch_enable : cap_en;
  assign next_start = {1'b0, sel_q} + {{CH_W{1'b0}}, 1'b1};

  flag_ch_classifier #(.N_CH(N_CH)) u_first (
    .en_mask   (first_mask),
    .start_idx ('0),
    .next_idx  (first_idx),
    .found     (first_found)
  );

  flag_ch_classifier #(.N_CH(N_CH)) u_next (
    .en_mask   (cap_en),
    .start_idx (next_start),
    .next_idx  (next_idx),
    .found     (next_found)
  );

  logic last_win;
  logic last_gap;
  assign last_win = (win_cnt == CNT_W'(1));
  assign last_gap = (gap_cnt == CNT_W'(1));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  // The sweep-advance decision is shared by CLOSE (no gap) and the last GAP
  // cycle. The selected channel is resolved when entering SELECT, so sel_ch
  // is already valid during the SELECT cycle itself.
  always_comb begin
    logic advance;
    state_d = state;
    sel_d   = sel_q;
    advance = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (first_found) begin
            state_d = ST_SELECT;
            sel_d   = first_idx;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SELECT: state_d = ST_OPEN;
      ST_OPEN: begin
        if (last_win) state_d = ST_CLOSE;
      end
      ST_CLOSE: begin
        if (cap_gap != '0) state_d = ST_GAP;
        else               advance = 1'b1;
      end
      ST_GAP: begin
        if (last_gap) advance = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (next_found) begin
        state_d = ST_SELECT;
        sel_d   = next_idx;
      end else if (continuous) begin
        // cap_en is known nonzero here, so first_found is set.
        state_d = ST_SELECT;
        sel_d   = first_idx;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  // ----------------------------------------------------------------- datapath
  // Window counter is loaded with max(win_len,1) and runs down to 1; the gap
  // counter likewise runs gap_len..1. Neither ever passes through zero, so
  // the all-ones length runs its full count without wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q   <= '0;
      win_cnt <= '0;
      gap_cnt <= '0;
      seen0   <= 1'b0;
      seen1   <= 1'b0;
      cap_win <= '0;
      cap_gap <= '0;
      cap_en  <= '0;
      flag_q  <= '0;
    end else begin
      sel_q <= sel_d;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            cap_win <= win_len;
            cap_gap <= gap_len;
            cap_en  <= ch_enable;
          end
        end
        ST_SELECT: begin
          seen0   <= 1'b0;
          seen1   <= 1'b0;
          win_cnt <= (cap_win == '0) ? CNT_W'(1) : cap_win;
        end
        ST_OPEN: begin
          if (flag_in[sel_q]) seen1 <= 1'b1;
          else                seen0 <= 1'b1;
          win_cnt <= win_cnt - CNT_W'(1);
        end
        ST_CLOSE: begin
          // Invalid windows leave the last stable value in place.
          if (!(seen0 && seen1)) flag_q[sel_q] <= seen1;
          gap_cnt <= cap_gap;
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    busy         = (state != ST_IDLE);
    window       = (state == ST_OPEN);
    result_valid = (state == ST_CLOSE);
    done         = (state == ST_DONE);
    sel_ch       = sel_q;
    result_ch    = (state == ST_CLOSE) ? sel_q : '0;
    result_code  = (state == ST_CLOSE) ? classify(seen0, seen1) : RES_NONE;
    flag_out     = flag_q;
  end

endmodule

// File: tb/tb_flag_window_scheduler.sv
// Purpose : self-checking bench for flag_window_scheduler against a timeline model.
// Latency : n/a.
// Backpressure: n/a.
module tb_flag_window_scheduler;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int CH_W  = $clog2(N_CH);
  localparam int MAXC  = 1024;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             continuous = 1'b0;
  logic [CNT_W-1:0] win_len = '0;
  logic [CNT_W-1:0] gap_len = '0;
  logic [N_CH-1:0]  ch_enable = '0;
  logic [N_CH-1:0]  flag_in = '0;
  logic             busy, window, result_valid, done;
  logic [CH_W-1:0]  sel_ch, result_ch;
  logic [1:0]       result_code;
  logic [N_CH-1:0]  flag_out;

  flag_window_scheduler #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .win_len      (win_len),
    .gap_len      (gap_len),
    .ch_enable    (ch_enable),
    .flag_in      (flag_in),
    .busy         (busy),
    .window       (window),
    .sel_ch       (sel_ch),
    .result_valid (result_valid),
    .result_ch    (result_ch),
    .result_code  (result_code),
    .flag_out     (flag_out),
    .done         (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus plans indexed by cycle relative to the start cycle (cycle 0).
  logic [N_CH-1:0] flag_plan [MAXC];
  bit              cont_plan [MAXC];

  // Expected per-cycle observations produced by the model.
  bit              e_win  [MAXC];
  bit              e_rv   [MAXC];
  bit              e_done [MAXC];
  bit              e_busy [MAXC];
  int              e_sel  [MAXC];
  int              e_rch  [MAXC];
  int              e_code [MAXC];
  logic [N_CH-1:0] e_fout [MAXC];
  int              run_len;
  logic [N_CH-1:0] model_fout = '0;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic plan_const(input logic [N_CH-1:0] v);
    for (int r = 0; r < MAXC; r++) begin
      flag_plan[r] = v;
      cont_plan[r] = 1'b0;
    end
  endtask

  // Random flags that mostly hold, so stable and invalid windows both occur.
  task automatic plan_random();
    logic [N_CH-1:0] v;
    v = N_CH'($urandom);
    for (int r = 0; r < MAXC; r++) begin
      for (int k = 0; k < N_CH; k++)
        if ($urandom_range(0, 9) == 0) v[k] = ~v[k];
      flag_plan[r] = v;
      cont_plan[r] = 1'b0;
    end
  endtask

  // Timeline model: each enabled channel occupies SELECT, W window cycles,
  // one result cycle and G gap cycles, in ascending order; a sweep restarts
  // when continuous is high in its last cycle, otherwise a DONE cycle follows.
  task automatic build_model(input logic [N_CH-1:0] en, input int w, input int g);
    int pos, weff, c;
    bit s0, s1, more;
    logic [N_CH-1:0] fo;
    for (int r = 0; r < MAXC; r++) begin
      e_win[r] = 0; e_rv[r] = 0; e_done[r] = 0; e_busy[r] = 0;
      e_sel[r] = 0; e_rch[r] = 0; e_code[r] = 0; e_fout[r] = model_fout;
    end
    weff = (w == 0) ? 1 : w;
    fo   = model_fout;
    pos  = 1;
    if (en != '0) begin
      more = 1;
      while (more) begin
        for (int k = 0; k < N_CH; k++) begin
          if (en[k]) begin
            s0 = 0; s1 = 0;
            e_busy[pos] = 1;
            for (int r = pos + 1; r <= pos + weff; r++) begin
              e_busy[r] = 1; e_win[r] = 1; e_sel[r] = k;
              if (flag_plan[r][k]) s1 = 1; else s0 = 1;
            end
            c = pos + weff + 1;
            e_busy[c] = 1; e_rv[c] = 1; e_rch[c] = k;
            e_code[c] = (s0 && s1) ? 3 : (s1 ? 2 : 1);
            if (!(s0 && s1)) fo[k] = s1;
            for (int r = c + 1; r < MAXC; r++) e_fout[r] = fo;
            for (int r = c + 1; r <= c + g; r++) e_busy[r] = 1;
            pos = c + g + 1;
          end
        end
        more = cont_plan[pos - 1];
      end
    end
    e_busy[pos] = 1;
    e_done[pos] = 1;
    run_len     = pos;
    model_fout  = fo;
  endtask

  // One run: start in cycle 0, then follow the plans through DONE and one
  // IDLE cycle. With scramble set, start is re-asserted and the config inputs
  // change while busy; both must have no effect on the run.
  task automatic run(input string name, input logic [N_CH-1:0] en, input int w, input int g, input bit scramble);
    build_model(en, w, g);
    @(posedge clk); #1;
    start = 1'b1; ch_enable = en; win_len = CNT_W'(w); gap_len = CNT_W'(g);
    flag_in = flag_plan[0]; continuous = cont_plan[0];
    @(negedge clk);
    chk({name, ".idle_busy"}, 0, 32'(busy), 32'(0));
    for (int r = 1; r <= run_len + 1; r++) begin
      @(posedge clk); #1;
      start      = (scramble && r <= run_len) ? 1'($urandom) : 1'b0;
      flag_in    = flag_plan[r];
      continuous = cont_plan[r];
      if (scramble) begin
        ch_enable = N_CH'($urandom);
        win_len   = CNT_W'($urandom_range(0, 6));
        gap_len   = CNT_W'($urandom_range(0, 6));
      end
      @(negedge clk);
      chk({name, ".busy"},   r, 32'(busy),         32'(e_busy[r]));
      chk({name, ".window"}, r, 32'(window),       32'(e_win[r]));
      chk({name, ".rvalid"}, r, 32'(result_valid), 32'(e_rv[r]));
      chk({name, ".done"},   r, 32'(done),         32'(e_done[r]));
      chk({name, ".fout"},   r, 32'(flag_out),     32'(e_fout[r]));
      if (e_win[r]) chk({name, ".sel_ch"}, r, 32'(sel_ch), 32'(e_sel[r]));
      if (e_rv[r]) begin
        chk({name, ".res_ch"},   r, 32'(result_ch),   32'(e_rch[r]));
        chk({name, ".res_code"}, r, 32'(result_code), 32'(e_code[r]));
      end
    end
    start = 1'b0;
    continuous = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy",   0, 32'(busy),         32'(0));
    chk("rst.window", 0, 32'(window),       32'(0));
    chk("rst.rvalid", 0, 32'(result_valid), 32'(0));
    chk("rst.done",   0, 32'(done),         32'(0));
    chk("rst.fout",   0, 32'(flag_out),     32'(0));
    chk("rst.sel",    0, 32'(sel_ch),       32'(0));
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("idle.busy", 0, 32'(busy), 32'(0));

    // Single channel, W=3, flag high throughout
    plan_const(4'b0001);
    run("single", 4'b0001, 3, 0, 0);
    chk("single.fout_const", 0, 32'(flag_out), 32'(4'b0001));

    // Edge in the second window cycle -> invalid, flag_out keeps its value
    plan_const(4'b0000);
    flag_plan[2] = 4'b0001;
    run("midedge", 4'b0001, 3, 0, 0);
    chk("midedge.fout_const", 0, 32'(flag_out), 32'(4'b0001));

    // Skip disabled channels, gap of 2 after each result
    plan_const(4'b1000);
    run("skipgap", 4'b1010, 2, 2, 0);
    chk("skipgap.fout_const", 0, 32'(flag_out), 32'(4'b1001));

    // Continuous: two sweeps of ch0,ch1; continuous dropped in ch1's window of sweep 2
    plan_random();
    for (int r = 0; r < 17; r++) cont_plan[r] = 1'b1;
    run("contin", 4'b0011, 2, 1, 0);

    // Empty enable mask: DONE right after IDLE, no result
    plan_const(4'b1111);
    run("empty", 4'b0000, 3, 2, 0);

    // win_len 0 behaves as a single window cycle
    plan_const(4'b0100);
    run("win0", 4'b0100, 0, 0, 0);

    // Start and config changes while busy are ignored
    plan_random();
    run("busystart", 4'b1101, 3, 1, 1);

    // Randomized runs
    for (int i = 0; i < 8; i++) begin
      plan_random();
      run("random", N_CH'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom_range(0, 3), 1);
    end

    // Full-count window and gap
    plan_const(4'b0000);
    flag_plan[100] = 4'b0010;
    run("maxcnt", 4'b0010, 255, 255, 0);

    // Reset in the middle of a window
    plan_const(4'b0101);
    run("prerst", 4'b1111, 2, 0, 0);
    chk("prerst.fout_const", 0, 32'(flag_out), 32'(4'b0101));
    @(posedge clk); #1;
    start = 1'b1; ch_enable = 4'b1111; win_len = 8'd4; gap_len = 8'd0; flag_in = 4'b0000;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst.pre_window", 2, 32'(window), 32'(1));
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("midrst.window", 4, 32'(window),       32'(0));
    chk("midrst.busy",   4, 32'(busy),         32'(0));
    chk("midrst.fout",   4, 32'(flag_out),     32'(0));
    chk("midrst.rvalid", 4, 32'(result_valid), 32'(0));
    chk("midrst.done",   4, 32'(done),         32'(0));
    model_fout = '0;
    plan_random();
    run("postrst", 4'b0110, 2, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
